// File: rtl/dma_bus_arbiter_pkg.sv
// Shared constants for the DMA bus arbiter: FSM state encoding and block geometry.
package dma_bus_arbiter_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_CMD      = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_GNT = 2'd2;
  localparam logic [STATE_W-1:0] ST_GRANT    = 2'd3;

  localparam int unsigned WORD_SIZE         = 32;
  localparam int unsigned DMA_BLOCK_WORDS   = 12;
  // DMA counts words 0..11 and then drops BR on interrupt, so BG stays high one extra cycle.
  localparam int unsigned DMA_NOMINAL_GRANT = DMA_BLOCK_WORDS + 1;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Handshake bundle between the DMA controller / CPU core and the bus arbiter.
//   dev_ready, cpu_mem_busy, BR, interrupt : towards the arbiter
//   cmd, BG, cpu_stall, dma_done, dma_err, xfer_count : from the arbiter
// Modports: slave = arbiter side, master = environment side.
interface dma_bus_arbiter_if #(
  parameter int unsigned CNT_W = 8
);

  logic             dev_ready;
  logic             cpu_mem_busy;
  logic             BR;
  logic             interrupt;
  logic             cmd;
  logic             BG;
  logic             cpu_stall;
  logic             dma_done;
  logic             dma_err;
  logic [CNT_W-1:0] xfer_count;

  modport slave (
    input  dev_ready, cpu_mem_busy, BR, interrupt,
    output cmd, BG, cpu_stall, dma_done, dma_err, xfer_count
  );

  modport master (
    output dev_ready, cpu_mem_busy, BR, interrupt,
    input  cmd, BG, cpu_stall, dma_done, dma_err, xfer_count
  );

endinterface

// File: rtl/dma_bus_arbiter_wdog_timer.sv
// Grant watchdog: counts cycles while run is high, flags expiry on the CYCLES-th cycle.
//   CLK, reset_n : clock, async active-low reset
//   clear        : restart the count from zero
//   run          : count this cycle (grant active)
//   expire_c     : combinational, high during the CYCLES-th running cycle
module dma_bus_arbiter_wdog_timer #(
  parameter int unsigned CYCLES = 32
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Running cycle counter, holds at the expiry value.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && !expire_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_c = run && (cnt_q == CW'(CYCLES - 1));

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU-side responder for the DMA bus handshake: issues cmd when a device block is ready,
// grants the bus once the CPU data port is idle, stalls the CPU during the grant, reports
// done/abort and counts completed transfers.
//   CLK, reset_n : clock, async active-low reset
//   bus (slave)  : dev_ready, cpu_mem_busy, BR, interrupt in;
//                  cmd, BG, cpu_stall, dma_done, dma_err, xfer_count out (all registered)
// Optional build macro DMA_WATCHDOG_EN adds a grant watchdog (WDOG_CYCLES).
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 8
`ifdef DMA_WATCHDOG_EN
  , parameter int unsigned WDOG_CYCLES = 32
`endif
) (
  input  logic            CLK,
  input  logic            reset_n,
  dma_bus_arbiter_if.slave bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               cmd_q, cmd_d;
  logic               bg_q, bg_d;
  logic               stall_q, stall_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pending_q, pending_d;
  logic               done_seen_q, done_seen_d;
  logic               br_ok;

`ifdef DMA_WATCHDOG_EN
  logic br_block_q, br_block_d;
  logic wdog_expire_c;

  dma_bus_arbiter_wdog_timer #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .clear    (state_q != ST_GRANT),
    .run      (state_q == ST_GRANT),
    .expire_c (wdog_expire_c)
  );
`endif

  // State and output registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 1'b0;
      bg_q        <= 1'b0;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      done_seen_q <= 1'b0;
`ifdef DMA_WATCHDOG_EN
      br_block_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bg_q        <= bg_d;
      stall_q     <= stall_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      done_seen_q <= done_seen_d;
`ifdef DMA_WATCHDOG_EN
      br_block_q  <= br_block_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bg_d        = bg_q;
    stall_d     = stall_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    count_d     = count_q;
    pending_d   = pending_q;
    done_seen_d = done_seen_q;
`ifdef DMA_WATCHDOG_EN
    // A BR left high after a watchdog abort is ignored until it is seen low once.
    br_block_d  = br_block_q && bus.BR;
    br_ok       = bus.BR && !br_block_q;
`else
    br_ok       = bus.BR;
`endif

    // One-deep request queue for blocks that arrive while busy.
    if (bus.dev_ready && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.dev_ready || pending_q) begin
          state_d   = ST_CMD;
          cmd_d     = 1'b1;
          pending_d = 1'b0;
        end
      end
      ST_CMD: begin
        if (br_ok) begin
          state_d = ST_WAIT_GNT;
          cmd_d   = 1'b0;
          stall_d = 1'b1;
        end
      end
      ST_WAIT_GNT: begin
        if (!bus.BR) begin
          state_d = ST_IDLE;
          stall_d = 1'b0;
          err_d   = 1'b1;
        end else if (!bus.cpu_mem_busy) begin
          state_d     = ST_GRANT;
          bg_d        = 1'b1;
          done_seen_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (bus.interrupt) begin
          done_seen_d = 1'b1;
        end
        if (!bus.BR) begin
          state_d = ST_IDLE;
          bg_d    = 1'b0;
          stall_d = 1'b0;
          if (done_seen_q || bus.interrupt) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef DMA_WATCHDOG_EN
        else if (wdog_expire_c) begin
          state_d    = ST_IDLE;
          bg_d       = 1'b0;
          stall_d    = 1'b0;
          err_d      = 1'b1;
          br_block_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd        = cmd_q;
  assign bus.BG         = bg_q;
  assign bus.cpu_stall  = stall_q;
  assign bus.dma_done   = done_q;
  assign bus.dma_err    = err_q;
  assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios plus randomized transfers
// scored against a transfer-level model (expected latencies and a completed-transfer count).
module tb_dma_bus_arbiter;
  import dma_bus_arbiter_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WDOG  = 32;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;

  dma_bus_arbiter_if #(.CNT_W(CNT_W)) bus ();

`ifdef DMA_WATCHDOG_EN
  dma_bus_arbiter #(.CNT_W(CNT_W), .WDOG_CYCLES(WDOG)) dut (
`else
  dma_bus_arbiter #(.CNT_W(CNT_W)) dut (
`endif
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  // One full transfer as seen by a DMA that raises BR one cycle after cmd.
  // nb: cycles cpu_mem_busy is held from the BR-sampling edge; glen: cycles BG should stay high;
  // mode: 0 abort, 1 interrupt with BR fall, 2 early interrupt pulse; rdy_at: dev_ready during
  // grant cycle rdy_at (glen = with BR fall, 0 = none). issue=0 means cmd is already high.
  task automatic run_xfer(input bit issue, input int nb, input int glen, input int mode,
                          input int rdy_at);
    int bg_edge;
    int m;
    logic want_bg;
    logic exp_done;
    logic exp_pend;
    logic [CNT_W-1:0] want_cnt;
    m = (mode == 2 && glen < 2) ? 1 : mode;
    bg_edge = (nb + 2 > 3) ? nb + 2 : 3;
    exp_pend = (rdy_at != 0);
    if (issue) begin
      bus.dev_ready = 1'b1;
      @(negedge CLK);
      bus.dev_ready = 1'b0;
    end
    total++;
    if (bus.cmd !== 1'b1) begin
      bad++; $display("FAIL cmd_rise: cmd=%b want 1 t=%0t", bus.cmd, $time);
    end
    @(negedge CLK);
    total++;
    if (bus.cmd !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      bad++; $display("FAIL cmd_hold: cmd=%b stall=%b want 1/0 t=%0t", bus.cmd, bus.cpu_stall, $time);
    end
    bus.BR = 1'b1;
    bus.cpu_mem_busy = (nb > 0);
    for (int e = 2; e <= bg_edge; e++) begin
      @(negedge CLK);
      bus.cpu_mem_busy = (e < nb + 1);
      want_bg = (e == bg_edge);
      total++;
      if (bus.BG !== want_bg || bus.cpu_stall !== 1'b1 || bus.cmd !== 1'b0) begin
        bad++; $display("FAIL grant_wait e=%0d: bg=%b stall=%b cmd=%b want bg=%b stall=1 cmd=0",
                        e, bus.BG, bus.cpu_stall, bus.cmd, want_bg);
      end
    end
    for (int g = 1; g < glen; g++) begin
      bus.interrupt = (m == 2 && g == 1);
      bus.dev_ready = (g == rdy_at);
      @(negedge CLK);
      bus.interrupt = 1'b0;
      bus.dev_ready = 1'b0;
      total++;
      if (bus.BG !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.dma_done !== 1'b0 || bus.dma_err !== 1'b0) begin
        bad++; $display("FAIL grant_hold g=%0d: bg=%b stall=%b done=%b err=%b want 1 1 0 0",
                        g, bus.BG, bus.cpu_stall, bus.dma_done, bus.dma_err);
      end
    end
    bus.BR = 1'b0;
    bus.interrupt = (m == 1);
    bus.dev_ready = (rdy_at >= glen);
    @(negedge CLK);
    bus.interrupt = 1'b0;
    bus.dev_ready = 1'b0;
    exp_done = (m != 0);
    if (exp_done) exp_count = (exp_count + 1) % (1 << CNT_W);
    want_cnt = CNT_W'(exp_count);
    total++;
    if (bus.BG !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.cmd !== 1'b0) begin
      bad++; $display("FAIL release: bg=%b stall=%b cmd=%b want 0 0 0", bus.BG, bus.cpu_stall, bus.cmd);
    end
    total++;
    if (bus.dma_done !== exp_done || bus.dma_err !== !exp_done) begin
      bad++; $display("FAIL status: done=%b err=%b want done=%b err=%b",
                      bus.dma_done, bus.dma_err, exp_done, !exp_done);
    end
    total++;
    if (bus.xfer_count !== want_cnt) begin
      bad++; $display("FAIL count: xfer_count=%0d want %0d", bus.xfer_count, want_cnt);
    end
    @(negedge CLK);
    total++;
    if (bus.dma_done !== 1'b0 || bus.dma_err !== 1'b0 || bus.cmd !== exp_pend) begin
      bad++; $display("FAIL after: done=%b err=%b cmd=%b want 0 0 %b",
                      bus.dma_done, bus.dma_err, bus.cmd, exp_pend);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    total++;
    if (bus.cmd !== 1'b0 || bus.BG !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dma_done !== 1'b0 ||
        bus.dma_err !== 1'b0 || bus.xfer_count !== '0) begin
      bad++; $display("FAIL reset: cmd=%b bg=%b stall=%b done=%b err=%b cnt=%0d want all 0",
                      bus.cmd, bus.BG, bus.cpu_stall, bus.dma_done, bus.dma_err, bus.xfer_count);
    end
    reset_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_nominal();
    run_xfer(1'b1, 0, int'(DMA_NOMINAL_GRANT), 1, 0);
  endtask

  task automatic test_busy();
    run_xfer(1'b1, 3, int'(DMA_NOMINAL_GRANT), 1, 0);
  endtask

  task automatic test_pending();
    run_xfer(1'b1, 0, int'(DMA_NOMINAL_GRANT), 1, 5);
    run_xfer(1'b0, 1, int'(DMA_NOMINAL_GRANT), 2, 0);
    total++;
    if (bus.xfer_count !== CNT_W'(4)) begin
      bad++; $display("FAIL pending_total: xfer_count=%0d want 4", bus.xfer_count);
    end
  endtask

  task automatic test_abort();
    run_xfer(1'b1, 0, 4, 0, 0);
  endtask

  task automatic test_spurious();
    bus.dev_ready = 1'b1;
    @(negedge CLK);
    bus.dev_ready = 1'b0;
    @(negedge CLK);
    bus.BR = 1'b1;
    bus.cpu_mem_busy = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if (bus.BG !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      bad++; $display("FAIL spur_wait: bg=%b stall=%b want 0 1", bus.BG, bus.cpu_stall);
    end
    bus.BR = 1'b0;
    @(negedge CLK);
    bus.cpu_mem_busy = 1'b0;
    total++;
    if (bus.dma_err !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.BG !== 1'b0 ||
        bus.xfer_count !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL spur_drop: err=%b stall=%b bg=%b cnt=%0d want 1 0 0 %0d",
                      bus.dma_err, bus.cpu_stall, bus.BG, bus.xfer_count, exp_count);
    end
    @(negedge CLK);
    total++;
    if (bus.dma_err !== 1'b0 || bus.cmd !== 1'b0) begin
      bad++; $display("FAIL spur_after: err=%b cmd=%b want 0 0", bus.dma_err, bus.cmd);
    end
  endtask

  task automatic test_random();
    bit issue;
    int nb;
    int glen;
    int mode;
    int rdy_at;
    issue = 1'b1;
    for (int i = 0; i < 24; i++) begin
      nb = int'($urandom_range(0, 4));
      glen = int'($urandom_range(1, 20));
      mode = int'($urandom_range(0, 2));
      rdy_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, glen)) : 0;
      run_xfer(issue, nb, glen, mode, rdy_at);
      issue = (rdy_at == 0);
    end
    if (!issue) run_xfer(1'b0, 0, 2, 1, 0);
  endtask

  task automatic test_reset_mid_grant();
    bus.dev_ready = 1'b1;
    @(negedge CLK);
    bus.dev_ready = 1'b0;
    @(negedge CLK);
    bus.BR = 1'b1;
    repeat (2) @(negedge CLK);
    repeat (5) @(negedge CLK);
    total++;
    if (bus.BG !== 1'b1) begin
      bad++; $display("FAIL rst_pre: bg=%b want 1", bus.BG);
    end
    #2 reset_n = 1'b0;
    #1;
    exp_count = 0;
    total++;
    if (bus.BG !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.xfer_count !== '0 ||
        bus.dma_done !== 1'b0 || bus.dma_err !== 1'b0) begin
      bad++; $display("FAIL rst_async: bg=%b stall=%b cnt=%0d done=%b err=%b want all 0",
                      bus.BG, bus.cpu_stall, bus.xfer_count, bus.dma_done, bus.dma_err);
    end
    bus.BR = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.dma_done !== 1'b0 || bus.dma_err !== 1'b0 || bus.cmd !== 1'b0 || bus.BG !== 1'b0) begin
      bad++; $display("FAIL rst_after: done=%b err=%b cmd=%b bg=%b want 0 0 0 0",
                      bus.dma_done, bus.dma_err, bus.cmd, bus.BG);
    end
  endtask

  task automatic test_wrap();
    while (exp_count != (1 << CNT_W) - 1) run_xfer(1'b1, 0, 1, 1, 0);
    total++;
    if (bus.xfer_count !== {CNT_W{1'b1}}) begin
      bad++; $display("FAIL wrap_pre: xfer_count=%0d want 255", bus.xfer_count);
    end
    run_xfer(1'b1, 0, 1, 1, 0);
    total++;
    if (bus.xfer_count !== '0) begin
      bad++; $display("FAIL wrap: xfer_count=%0d want 0", bus.xfer_count);
    end
  endtask

`ifdef DMA_WATCHDOG_EN
  task automatic test_watchdog();
    bus.dev_ready = 1'b1;
    @(negedge CLK);
    bus.dev_ready = 1'b0;
    @(negedge CLK);
    bus.BR = 1'b1;
    repeat (2) @(negedge CLK);
    for (int g = 0; g < int'(WDOG); g++) begin
      if (g != 0) @(negedge CLK);
      total++;
      if (bus.BG !== 1'b1) begin
        bad++; $display("FAIL wdog_hold g=%0d: bg=%b want 1", g, bus.BG);
      end
    end
    @(negedge CLK);
    total++;
    if (bus.BG !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dma_err !== 1'b1 || bus.dma_done !== 1'b0 ||
        bus.xfer_count !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL wdog_fire: bg=%b stall=%b err=%b done=%b cnt=%0d want 0 0 1 0 %0d",
                      bus.BG, bus.cpu_stall, bus.dma_err, bus.dma_done, bus.xfer_count, exp_count);
    end
    bus.dev_ready = 1'b1;
    @(negedge CLK);
    bus.dev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      total++;
      if (bus.cmd !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.BG !== 1'b0) begin
        bad++; $display("FAIL wdog_block i=%0d: cmd=%b stall=%b bg=%b want 1 0 0",
                        i, bus.cmd, bus.cpu_stall, bus.BG);
      end
    end
    bus.BR = 1'b0;
    @(negedge CLK);
    bus.BR = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.cmd !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      bad++; $display("FAIL wdog_rearm: cmd=%b stall=%b want 0 1", bus.cmd, bus.cpu_stall);
    end
    @(negedge CLK);
    bus.BR = 1'b0;
    bus.interrupt = 1'b1;
    @(negedge CLK);
    bus.interrupt = 1'b0;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    total++;
    if (bus.dma_done !== 1'b1 || bus.xfer_count !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL wdog_after: done=%b cnt=%0d want 1 %0d", bus.dma_done, bus.xfer_count, exp_count);
    end
    @(negedge CLK);
  endtask
`endif

  initial begin
    bus.dev_ready = 1'b0;
    bus.cpu_mem_busy = 1'b0;
    bus.BR = 1'b0;
    bus.interrupt = 1'b0;
    test_reset();
    test_nominal();
    test_busy();
    test_pending();
    test_abort();
    test_spurious();
    test_random();
    test_reset_mid_grant();
    test_wrap();
`ifdef DMA_WATCHDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
